// File: rtl/screen_phase_ctrl_pkg.sv
// Shared phase encoding, layer bit indices and per-phase layer masks for screen_phase_ctrl.
// Optional pause support is enabled elsewhere by defining SCREEN_PHASE_PAUSE_EN.
package screen_phase_pkg;

  typedef enum logic [2:0] {
    PhaseIdle   = 3'd0,
    PhaseReady  = 3'd1,
    PhasePlay   = 3'd2,
    PhaseDying  = 3'd3,
    PhaseWin    = 3'd4,
    PhaseLose   = 3'd5,
    PhasePaused = 3'd6
  } phase_t;

  localparam int unsigned LayerWin     = 0;
  localparam int unsigned LayerLose    = 1;
  localparam int unsigned LayerPacman  = 2;
  localparam int unsigned LayerMonster = 3;
  localparam int unsigned LayerHeart   = 4;
  localparam int unsigned LayerHammer  = 5;
  localparam int unsigned LayerText    = 6;
  localparam int unsigned LayerMaze    = 7;

  localparam int unsigned FrameCntW        = 8;
  // Key edges in WIN/LOSE are ignored until this many frames have elapsed.
  localparam int unsigned KeyHoldoffFrames = 30;

  localparam logic [7:0] BitPacman  = 8'(1 << LayerPacman);
  localparam logic [7:0] MaskPlay   = 8'(1 << LayerPacman) | 8'(1 << LayerMonster) |
                                      8'(1 << LayerHeart) | 8'(1 << LayerHammer) |
                                      8'(1 << LayerText) | 8'(1 << LayerMaze);
  localparam logic [7:0] MaskDying  = MaskPlay & ~(8'(1 << LayerMonster)) & ~BitPacman;
  localparam logic [7:0] MaskWin    = 8'(1 << LayerWin) | 8'(1 << LayerMaze);
  localparam logic [7:0] MaskLose   = 8'(1 << LayerLose) | 8'(1 << LayerMaze);

  function automatic logic [7:0] layer_mask(phase_t ph, logic blink);
    case (ph)
      PhaseIdle, PhaseReady, PhasePlay, PhasePaused: return MaskPlay;
      PhaseDying: return MaskDying | (blink ? BitPacman : 8'h00);
      PhaseWin:   return MaskWin;
      PhaseLose:  return MaskLose;
      default:    return 8'h00;
    endcase
  endfunction

  // True on the tick that brings the frame count up to limit.
  function automatic logic frame_limit(logic tick, logic [FrameCntW-1:0] count,
                                       int unsigned limit);
    return tick && (count == FrameCntW'(limit - 1));
  endfunction

endpackage

// File: rtl/screen_phase_ctrl_if.sv
// Handshake bundle between the game logic and screen_phase_ctrl.
// pauseKey exists only when SCREEN_PHASE_PAUSE_EN is defined.
interface screen_phase_ctrl_if;
  import screen_phase_pkg::*;

  logic       startOfFrame;
  logic       startKey;
  logic       allCoinsEaten;
  logic       pacmanHit;
  logic       timeUp;
`ifdef SCREEN_PHASE_PAUSE_EN
  logic       pauseKey;
`endif
  phase_t     phase;
  logic [7:0] layerMask;
  logic       freeze;
  logic       newLevelPulse;
  logic [2:0] livesLeft;

`ifdef SCREEN_PHASE_PAUSE_EN
  modport master (
    output startOfFrame, startKey, allCoinsEaten, pacmanHit, timeUp, pauseKey,
    input  phase, layerMask, freeze, newLevelPulse, livesLeft
  );
  modport slave (
    input  startOfFrame, startKey, allCoinsEaten, pacmanHit, timeUp, pauseKey,
    output phase, layerMask, freeze, newLevelPulse, livesLeft
  );
`else
  modport master (
    output startOfFrame, startKey, allCoinsEaten, pacmanHit, timeUp,
    input  phase, layerMask, freeze, newLevelPulse, livesLeft
  );
  modport slave (
    input  startOfFrame, startKey, allCoinsEaten, pacmanHit, timeUp,
    output phase, layerMask, freeze, newLevelPulse, livesLeft
  );
`endif

endinterface

// File: rtl/screen_phase_ctrl_phase_frame_timer.sv
// Per-phase frame counter (saturating) with a blink toggle that starts high on clear
// and flips every BLINK_FRAMES ticks.
module phase_frame_timer #(
  parameter int unsigned CntW         = 8,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            clr,
  input  logic            tick,
  output logic [CntW-1:0] count,
  output logic            blinkNext
);

  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CntW-1:0]   count_q, count_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  always_comb begin
    count_d     = count_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (clr) begin
      count_d     = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (tick) begin
      if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      count_q     <= count_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign count     = count_q;
  assign blinkNext = blink_d;

endmodule

// File: rtl/screen_phase_ctrl.sv
// Game-phase sequencer: phase FSM, lives count, layer enable mask and freeze strobe.
// Define SCREEN_PHASE_PAUSE_EN to add the pauseKey input and the PAUSED phase.
module screen_phase_ctrl
  import screen_phase_pkg::*;
#(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned DEATH_FRAMES = 90,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input logic                clk,
  input logic                resetN,
  screen_phase_ctrl_if.slave bus
);

  phase_t               state_q, state_d;
  logic [2:0]           lives_q, lives_d;
  logic [7:0]           mask_q;
  logic                 freeze_q;
  logic                 pulse_q;
  logic                 key_q, key_qq, key_edge;
  logic                 frame_clr, frame_tick, blink_nxt;
  logic [FrameCntW-1:0] frame_cnt;

  // Key history resets high so a key held through reset produces no edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_q  <= 1'b1;
      key_qq <= 1'b1;
    end else begin
      key_q  <= bus.startKey;
      key_qq <= key_q;
    end
  end
  assign key_edge = key_q & ~key_qq;

`ifdef SCREEN_PHASE_PAUSE_EN
  logic pause_q, pause_qq, pause_edge;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pause_q  <= 1'b1;
      pause_qq <= 1'b1;
    end else begin
      pause_q  <= bus.pauseKey;
      pause_qq <= pause_q;
    end
  end
  assign pause_edge = pause_q & ~pause_qq;
`endif

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    case (state_q)
      PhaseIdle: begin
        if (key_edge) begin
          state_d = PhaseReady;
          lives_d = 3'(INIT_LIVES);
        end
      end
      PhaseReady: begin
        if (frame_limit(frame_tick, frame_cnt, READY_FRAMES)) state_d = PhasePlay;
      end
      PhasePlay: begin
        if (bus.allCoinsEaten)  state_d = PhaseWin;
        else if (bus.timeUp)    state_d = PhaseLose;
        else if (bus.pacmanHit) state_d = PhaseDying;
`ifdef SCREEN_PHASE_PAUSE_EN
        else if (pause_edge)    state_d = PhasePaused;
`endif
      end
      PhaseDying: begin
        if (frame_limit(frame_tick, frame_cnt, DEATH_FRAMES)) begin
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          state_d = (lives_q <= 3'd1) ? PhaseLose : PhaseReady;
        end
      end
      PhaseWin, PhaseLose: begin
        if (key_edge && (frame_cnt >= FrameCntW'(KeyHoldoffFrames))) state_d = PhaseIdle;
      end
`ifdef SCREEN_PHASE_PAUSE_EN
      PhasePaused: begin
        if (pause_edge) state_d = PhasePlay;
      end
`endif
      default: state_d = PhaseIdle;
    endcase
  end

  // Pausing must not disturb the frame count, so PLAY<->PAUSED is not a fresh entry.
  always_comb begin
    frame_clr  = (state_d != state_q);
    frame_tick = bus.startOfFrame;
`ifdef SCREEN_PHASE_PAUSE_EN
    if ((state_q == PhasePlay && state_d == PhasePaused) ||
        (state_q == PhasePaused && state_d == PhasePlay)) begin
      frame_clr = 1'b0;
    end
    if (state_q == PhasePaused) frame_tick = 1'b0;
`endif
  end

  phase_frame_timer #(
    .CntW         (FrameCntW),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk       (clk),
    .resetN    (resetN),
    .clr       (frame_clr),
    .tick      (frame_tick),
    .count     (frame_cnt),
    .blinkNext (blink_nxt)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= PhaseIdle;
      lives_q  <= 3'd0;
      mask_q   <= 8'h00;
      freeze_q <= 1'b1;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      mask_q   <= layer_mask(state_d, blink_nxt);
      freeze_q <= (state_d != PhasePlay);
      pulse_q  <= (state_q == PhaseIdle) && (state_d == PhaseReady);
    end
  end

  assign bus.phase         = state_q;
  assign bus.layerMask     = mask_q;
  assign bus.freeze        = freeze_q;
  assign bus.newLevelPulse = pulse_q;
  assign bus.livesLeft     = lives_q;

endmodule

// File: tb/tb_screen_phase_ctrl.sv
// Self-checking bench for screen_phase_ctrl: directed phase walk plus randomized stimulus
// compared every cycle against a rule-level reference model.
module tb_screen_phase_ctrl;

  localparam int InitLives   = 3;
  localparam int ReadyFrames = 120;
  localparam int DeathFrames = 90;
  localparam int BlinkFrames = 8;
  localparam int Holdoff     = 30;

  localparam int PIdle  = 0;
  localparam int PReady = 1;
  localparam int PPlay  = 2;
  localparam int PDying = 3;
  localparam int PWin   = 4;
  localparam int PLose  = 5;

  logic clk    = 1'b0;
  logic resetN = 1'b1;
  logic sof, key, coins, hit, tup;

  screen_phase_ctrl_if bus();

  assign bus.startOfFrame  = sof;
  assign bus.startKey      = key;
  assign bus.allCoinsEaten = coins;
  assign bus.pacmanHit     = hit;
  assign bus.timeUp        = tup;
`ifdef SCREEN_PHASE_PAUSE_EN
  assign bus.pauseKey      = 1'b0;
`endif

  screen_phase_ctrl #(
    .INIT_LIVES   (InitLives),
    .READY_FRAMES (ReadyFrames),
    .DEATH_FRAMES (DeathFrames),
    .BLINK_FRAMES (BlinkFrames)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: phase, frames seen since entering it, lives, expected outputs.
  int m_phase, m_frames, m_lives, m_mask;
  bit m_freeze, m_pulse;
  bit hist1, hist2;  // last two sampled startKey values, most recent first

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_mask(input int ph, input int f);
    case (ph)
      PIdle, PReady, PPlay: return 'hFC;
      PDying: return (((f / BlinkFrames) % 2) == 0) ? 'hF4 : 'hF0;
      PWin:   return 'h81;
      PLose:  return 'h82;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = PIdle; m_frames = 0; m_lives = 0; m_mask = 0;
    m_freeze = 1'b1; m_pulse = 1'b0; hist1 = 1'b1; hist2 = 1'b1;
  endtask

  task automatic model_update();
    bit kedge;
    int nf, nxt;
    kedge = hist1 && !hist2;
    hist2 = hist1;
    hist1 = key;
    nf = m_frames + (sof ? 1 : 0);
    if (nf > 255) nf = 255;
    nxt = m_phase;
    m_pulse = 1'b0;
    case (m_phase)
      PIdle: if (kedge) begin nxt = PReady; m_lives = InitLives; m_pulse = 1'b1; end
      PReady: if (sof && nf == ReadyFrames) nxt = PPlay;
      PPlay: begin
        if (coins) nxt = PWin;
        else if (tup) nxt = PLose;
        else if (hit) nxt = PDying;
      end
      PDying: if (sof && nf == DeathFrames) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        nxt = (m_lives == 0) ? PLose : PReady;
      end
      PWin, PLose: if (kedge && m_frames >= Holdoff) nxt = PIdle;
      default: nxt = PIdle;
    endcase
    m_frames = (nxt != m_phase) ? 0 : nf;
    m_phase  = nxt;
    m_freeze = (m_phase != PPlay);
    m_mask   = exp_mask(m_phase, m_frames);
  endtask

  task automatic compare_all();
    check_eq("phase", int'(bus.phase), m_phase);
    check_eq("mask", int'(bus.layerMask), m_mask);
    check_eq("freeze", int'(bus.freeze), int'(m_freeze));
    check_eq("pulse", int'(bus.newLevelPulse), int'(m_pulse));
    check_eq("lives", int'(bus.livesLeft), m_lives);
  endtask

  task automatic step();
    @(posedge clk);
    if (resetN) model_update();
    else model_reset();
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    resetN = 1'b0;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    resetN = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1; step();
      sof = 1'b0; step(); step();
    end
  endtask

  task automatic press_key();
    key = 1'b1; step(); step(); step();
    key = 1'b0; step();
  endtask

  task automatic frames_until(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && m_phase != target; i++) frames(1);
    check_eq(tag, int'(bus.phase), target);
  endtask

  task automatic kill_pacman();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  initial begin
    int gap;
    sof = 0; key = 0; coins = 0; hit = 0; tup = 0;
    model_reset();
    #2;
    apply_reset();
    step(); step(); step();

    // New game: one-cycle pulse, lives loaded, READY -> PLAY after exactly 120 frames.
    key = 1'b1; step();
    check_eq("pulse_early", int'(bus.newLevelPulse), 0);
    step();
    check_eq("pulse_on", int'(bus.newLevelPulse), 1);
    check_eq("lives_init", int'(bus.livesLeft), InitLives);
    check_eq("ready", int'(bus.phase), PReady);
    step();
    check_eq("pulse_off", int'(bus.newLevelPulse), 0);
    key = 1'b0; step();
    frames(ReadyFrames - 1);
    check_eq("ready_119", int'(bus.phase), PReady);
    frames(1);
    check_eq("play", int'(bus.phase), PPlay);
    check_eq("play_freeze", int'(bus.freeze), 0);

    // Death: blink every 8 frames, back to READY with one life less, no pulse.
    kill_pacman();
    check_eq("dying", int'(bus.phase), PDying);
    check_eq("dying_mask0", int'(bus.layerMask), 'hF4);
    frames(BlinkFrames);
    check_eq("dying_mask8", int'(bus.layerMask), 'hF0);
    frames(BlinkFrames);
    check_eq("dying_mask16", int'(bus.layerMask), 'hF4);
    frames(DeathFrames - 2 * BlinkFrames - 1);
    check_eq("dying_89", int'(bus.phase), PDying);
    frames(1);
    check_eq("rebirth", int'(bus.phase), PReady);
    check_eq("lives_2", int'(bus.livesLeft), 2);

    // Two more deaths exhaust the lives.
    frames_until("play2", PPlay, 200);
    kill_pacman();
    frames_until("ready3", PReady, 200);
    check_eq("lives_1", int'(bus.livesLeft), 1);
    frames_until("play3", PPlay, 200);
    kill_pacman();
    frames_until("lose", PLose, 200);
    check_eq("lose_mask", int'(bus.layerMask), 'h82);
    check_eq("lives_0", int'(bus.livesLeft), 0);

    // Key hold-off in LOSE.
    frames(10);
    press_key();
    check_eq("lose_holdoff", int'(bus.phase), PLose);
    frames(25);
    press_key();
    check_eq("lose_exit", int'(bus.phase), PIdle);

    // Coins beat a simultaneous hit.
    press_key();
    frames_until("play4", PPlay, 200);
    coins = 1'b1; hit = 1'b1; step(); coins = 1'b0; hit = 1'b0;
    check_eq("win", int'(bus.phase), PWin);
    check_eq("win_mask", int'(bus.layerMask), 'h81);

    // Timer beats a simultaneous hit.
    frames(Holdoff);
    press_key();
    press_key();
    frames_until("play5", PPlay, 200);
    tup = 1'b1; hit = 1'b1; step(); tup = 1'b0; hit = 1'b0;
    check_eq("timeup_lose", int'(bus.phase), PLose);

    // Reset in DYING, key held high through reset.
    frames(Holdoff);
    press_key();
    press_key();
    frames_until("play6", PPlay, 200);
    kill_pacman();
    frames(5);
    key = 1'b1;
    apply_reset();
    check_eq("rst_phase", int'(bus.phase), PIdle);
    repeat (5) step();
    check_eq("held_key", int'(bus.phase), PIdle);
    key = 1'b0; step();
    key = 1'b1; step(); step();
    check_eq("key_again", int'(bus.phase), PReady);
    key = 1'b0;

    // Randomized traffic against the model.
    gap = 0;
    for (int c = 0; c < 20000 && failures < 50; c++) begin
      if (gap == 0) begin
        sof = 1'b1;
        gap = $urandom_range(4, 1);
      end else begin
        sof = 1'b0;
        gap--;
      end
      if ($urandom_range(29, 0) == 0) key = ~key;
      coins = ($urandom_range(599, 0) == 0);
      tup   = ($urandom_range(599, 0) == 0);
      hit   = ($urandom_range(99, 0) == 0);
      if ($urandom_range(5999, 0) == 0) apply_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_phase_ctrl.md
# screen_phase_ctrl

Game-phase sequencer for the VGA output path. It tracks the game phase (title, ready countdown, play, death, win, lose) on frame boundaries, owns the lives count, and drives the per-layer enable mask that gates each object's drawing request before the object priority mux. It also drives the win/lose overlay enables and the freeze strobe consumed by the movement logic.

## Interface
- INIT_LIVES, 3: lives loaded on new game (1..7)
- READY_FRAMES, 120: frames spent in READY before PLAY
- DEATH_FRAMES, 90: frames spent in DYING
- BLINK_FRAMES, 8: half-period of pacman blink in DYING, in frames
- clk  in  1  system clock; one clock; reset is asynchronous and active-low
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- startKey  in  1  level from keypad; rising edge detected internally
- allCoinsEaten  in  1  level; level cleared
- pacmanHit  in  1  level; monster collision without hammer
- timeUp  in  1  level; game timer expired
- phase  out  3  current phase_t encoding
- layerMask  out  8  per-layer enable, bit index per package constants
- freeze  out  1  high when movement must not update
- newLevelPulse  out  1  one-cycle pulse on entry to READY from IDLE
- livesLeft  out  3  current lives, feeds heart display

## Operation
- States: IDLE, READY, PLAY, DYING, WIN, LOSE.
- IDLE: startKey edge -> READY, livesLeft <= INIT_LIVES, newLevelPulse.
- READY: after READY_FRAMES startOfFrame pulses -> PLAY.
- PLAY priority per cycle: allCoinsEaten -> WIN; else timeUp -> LOSE; else pacmanHit -> DYING.
- DYING: after DEATH_FRAMES frames, livesLeft decrements; result 0 -> LOSE, else -> READY (no newLevelPulse).
- WIN/LOSE: startKey edge -> IDLE; edges during the first 30 frames of WIN/LOSE ignored.
- Frame counter clears on every state entry; counts startOfFrame pulses only.
- layerMask: IDLE/READY all play layers on, win/lose bits off; PLAY all play layers on; DYING monster off, pacman bit toggles every BLINK_FRAMES frames starting on; WIN only win+walls; LOSE only lose+walls.
- freeze = 1 in all states except PLAY.
- livesLeft saturates at 0; never wraps.

## Timing
- All outputs registered; state change visible on phase/layerMask/freeze one cycle after the triggering input cycle.
- startKey edge detect adds one cycle: edge recognized the cycle after the 0->1 sample.
- Frame-limit transitions occur on the cycle after the startOfFrame pulse that reaches the limit.
- Reset values: phase=IDLE, layerMask=8'h00, freeze=1, newLevelPulse=0, livesLeft=0, counters 0.
- Reset mid-frame or mid-phase: immediate return to IDLE, no pulse emitted.
- startKey held high through reset: no edge until it drops and rises again.

## Configuration
- SCREEN_PHASE_PAUSE_EN defined: extra input pauseKey and state PAUSED; pauseKey edge in PLAY -> PAUSED, again -> PLAY; PAUSED keeps layerMask of PLAY, freeze=1, frame counter held.
- Undefined: no pauseKey port, no PAUSED state; behaviour otherwise identical.

## Structure
- screen_phase_pkg: phase_t enum (IDLE=0..LOSE=5, PAUSED=6), layer bit indices (WIN=0, LOSE=1, PACMAN=2, MONSTER=3, HEART=4, HAMMER=5, TEXT=6, MAZE=7), mask constants per phase.
- Sub-module phase_frame_timer: clear/enable frame counter with terminal-count compare and blink toggle.

## Test plan
- Reset, startKey edge -> newLevelPulse 1 cycle, livesLeft=3, phase READY; after 120 frames phase PLAY, freeze=0.
- PLAY, pacmanHit -> DYING, layerMask[2] toggles every 8 frames; after 90 frames livesLeft=2, phase READY.
- Three deaths from INIT_LIVES=3 -> LOSE, layerMask=8'h82, livesLeft=0.
- allCoinsEaten and pacmanHit same cycle in PLAY -> WIN, layerMask=8'h81.
- In LOSE, startKey edge at frame 10 ignored, edge at frame 35 -> IDLE.
- resetN low during DYING -> phase IDLE, layerMask=0 immediately; with SCREEN_PHASE_PAUSE_EN, pause in PLAY holds frame counter and freeze=1.
